// File: rtl/tl_pkg.sv
// Shared TileLink-UL constants and error-bit indices for the in-flight tracker.
package tl_pkg;

  localparam int ERR_W = 8;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;
  localparam logic [2:0] ACK         = 3'd0;
  localparam logic [2:0] ACK_DATA    = 3'd1;

  typedef enum logic [2:0] {
    ERR_A_SRC_BUSY = 3'd0,
    ERR_D_SRC_IDLE = 3'd1,
    ERR_D_OPCODE   = 3'd2,
    ERR_D_SIZE     = 3'd3,
    ERR_D_BURST    = 3'd4,
    ERR_TIMEOUT    = 3'd5,
    ERR_A_OPCODE   = 3'd6,
    ERR_RESERVED   = 3'd7
  } err_e;

  function automatic logic is_legal_a_opcode(input logic [2:0] op);
    return (op == PUT_FULL) || (op == PUT_PARTIAL) || (op == GET);
  endfunction

endpackage

// File: rtl/tl_trk_watchdog.sv
// No-progress watchdog: counts stalled cycles and raises a single-cycle hit
// once the limit is reached, staying quiet until the clear condition returns.
module tl_trk_watchdog #(
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic timeout_hit
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_STALL = CNT_W'((TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] stall_cnt;
  logic             fired;

  // The hit lands on the cycle that completes the TIMEOUT_CYC-th stalled cycle.
  assign timeout_hit = (TIMEOUT_CYC != 0) && !clear && !fired && (stall_cnt == LAST_STALL);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      fired     <= 1'b0;
    end else if (clear) begin
      stall_cnt <= '0;
      fired     <= 1'b0;
    end else if (!fired) begin
      stall_cnt <= stall_cnt + CNT_ONE;
      if (timeout_hit) fired <= 1'b1;
    end
  end

endmodule

// File: rtl/tl_inflight_tracker.sv
// Passive TL-UL scoreboard: records A requests per source ID, checks D responses
// against them, counts outstanding transactions and flags protocol errors.
module tl_inflight_tracker
  import tl_pkg::*;
#(
  parameter int SOURCE_W    = 7,
  parameter int SIZE_W      = 4,
  parameter int BEAT_BYTES  = 4,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                a_valid,
  input  logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [SIZE_W-1:0]   a_size,
  input  logic [SOURCE_W-1:0] a_source,
  input  logic                d_valid,
  input  logic                d_ready,
  input  logic [2:0]          d_opcode,
  input  logic [SIZE_W-1:0]   d_size,
  input  logic [SOURCE_W-1:0] d_source,
  input  logic                err_clear,
  output logic [SOURCE_W:0]   outstanding,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_code
);

  localparam int NUM_IDS    = 2 ** SOURCE_W;
  localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
  localparam int BEAT_W     = 2 ** SIZE_W;
  localparam logic [BEAT_W-1:0] BEAT_ONE = BEAT_W'(1);
  localparam logic [SOURCE_W:0] OUT_ONE  = (SOURCE_W + 1)'(1);

  function automatic logic [BEAT_W-1:0] beats_for(input logic get, input logic [SIZE_W-1:0] sz);
    if (!get || (int'(sz) <= BEAT_SHIFT)) return BEAT_ONE;
    return BEAT_ONE << (int'(sz) - BEAT_SHIFT);
  endfunction

  logic [NUM_IDS-1:0] inflight;
  logic               is_get_tbl [NUM_IDS];
  logic [SIZE_W-1:0]  size_tbl   [NUM_IDS];

  logic                in_burst;
  logic [BEAT_W-1:0]   beats_left;
  logic [SOURCE_W-1:0] burst_src;
  logic [2:0]          burst_op;
  logic [SIZE_W-1:0]   burst_size;
  logic                burst_ign;

  logic [SOURCE_W:0]   outstanding_q;
  logic                err_pulse_q;
  logic [ERR_W-1:0]    err_code_q;

  logic                a_fire, d_fire, first_beat, src_hit;
  logic                a_legal, a_busy, a_alloc, d_last, d_retire;
  logic [SOURCE_W-1:0] retire_src;
  logic [BEAT_W-1:0]   first_beats;
  logic [ERR_W-1:0]    new_bits;
  logic                wd_clear, timeout_hit;

  // Idle-source bursts have no table entry, so their length is taken from the D header itself.
  always_comb begin
    a_fire      = a_valid && a_ready;
    d_fire      = d_valid && d_ready;
    first_beat  = d_fire && !in_burst;
    src_hit     = inflight[d_source];
    first_beats = src_hit ? beats_for(is_get_tbl[d_source], size_tbl[d_source])
                          : beats_for(d_opcode == ACK_DATA, d_size);
    d_last      = in_burst ? (beats_left == BEAT_ONE) : (first_beats == BEAT_ONE);
    d_retire    = d_fire && d_last && (in_burst ? !burst_ign : src_hit);
    retire_src  = in_burst ? burst_src : d_source;
    a_legal     = is_legal_a_opcode(a_opcode);
    a_busy      = inflight[a_source] && !(d_retire && (retire_src == a_source));
    a_alloc     = a_fire && a_legal && !a_busy;
  end

  always_comb begin
    new_bits                 = '0;
    new_bits[ERR_A_SRC_BUSY] = a_fire && a_legal && a_busy;
    new_bits[ERR_A_OPCODE]   = a_fire && !a_legal;
    new_bits[ERR_D_SRC_IDLE] = first_beat && !src_hit;
    new_bits[ERR_D_OPCODE]   = first_beat && src_hit &&
                               (is_get_tbl[d_source] != (d_opcode == ACK_DATA));
    new_bits[ERR_D_SIZE]     = first_beat && src_hit && (d_size != size_tbl[d_source]);
    new_bits[ERR_D_BURST]    = d_fire && in_burst && !burst_ign &&
                               ((d_source != burst_src) || (d_opcode != burst_op) ||
                                (d_size != burst_size));
    new_bits[ERR_TIMEOUT]    = timeout_hit;
  end

  assign wd_clear = d_fire || (outstanding_q == '0);

  tl_trk_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear       (wd_clear),
    .timeout_hit (timeout_hit)
  );

  // Retire is applied before allocate so a same-cycle reuse of one ID ends up in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight <= '0;
    end else begin
      if (d_retire) inflight[retire_src] <= 1'b0;
      if (a_alloc)  inflight[a_source]   <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (a_alloc) begin
      is_get_tbl[a_source] <= (a_opcode == GET);
      size_tbl[a_source]   <= a_size;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_burst   <= 1'b0;
      beats_left <= '0;
      burst_src  <= '0;
      burst_op   <= '0;
      burst_size <= '0;
      burst_ign  <= 1'b0;
    end else if (d_fire) begin
      if (!in_burst) begin
        if (!d_last) begin
          in_burst   <= 1'b1;
          beats_left <= first_beats - BEAT_ONE;
          burst_src  <= d_source;
          burst_op   <= d_opcode;
          burst_size <= d_size;
          burst_ign  <= !src_hit;
        end
      end else begin
        beats_left <= beats_left - BEAT_ONE;
        if (d_last) in_burst <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding_q <= '0;
    end else begin
      case ({a_alloc, d_retire})
        2'b10:   outstanding_q <= outstanding_q + OUT_ONE;
        2'b01:   outstanding_q <= outstanding_q - OUT_ONE;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_pulse_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      err_pulse_q <= |new_bits;
      err_code_q  <= err_clear ? new_bits : (err_code_q | new_bits);
    end
  end

  assign outstanding = outstanding_q;
  assign err_pulse   = err_pulse_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_tl_inflight_tracker.sv
// Randomized and directed bench for tl_inflight_tracker against a transaction-level model.
`timescale 1ns/1ps
module tb_tl_inflight_tracker;

  localparam int SOURCE_W    = 7;
  localparam int SIZE_W      = 4;
  localparam int BEAT_BYTES  = 4;
  localparam int TIMEOUT_CYC = 4096;
  localparam int NUM_IDS     = 2 ** SOURCE_W;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                a_valid = 1'b0, a_ready = 1'b0;
  logic [2:0]          a_opcode = '0;
  logic [SIZE_W-1:0]   a_size = '0;
  logic [SOURCE_W-1:0] a_source = '0;
  logic                d_valid = 1'b0, d_ready = 1'b0;
  logic [2:0]          d_opcode = '0;
  logic [SIZE_W-1:0]   d_size = '0;
  logic [SOURCE_W-1:0] d_source = '0;
  logic                err_clear = 1'b0;
  logic [SOURCE_W:0]   outstanding;
  logic                err_pulse;
  logic [7:0]          err_code;

  tl_inflight_tracker #(
    .SOURCE_W    (SOURCE_W),
    .SIZE_W      (SIZE_W),
    .BEAT_BYTES  (BEAT_BYTES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_opcode    (a_opcode),
    .a_size      (a_size),
    .a_source    (a_source),
    .d_valid     (d_valid),
    .d_ready     (d_ready),
    .d_opcode    (d_opcode),
    .d_size      (d_size),
    .d_source    (d_source),
    .err_clear   (err_clear),
    .outstanding (outstanding),
    .err_pulse   (err_pulse),
    .err_code    (err_code)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit check_en = 1'b0;

  // Reference model: whole transactions tracked per ID, errors as plain bit masks.
  bit m_inflight [NUM_IDS];
  bit m_get      [NUM_IDS];
  int m_size     [NUM_IDS];
  int m_out, m_code, m_pulse, m_stall;
  int m_left, m_bsrc, m_bop, m_bsize;
  bit m_bign;

  function automatic int num_beats(input bit get, input int size);
    int bytes;
    bytes = 1 << size;
    if (!get || bytes < BEAT_BYTES) return 1;
    return bytes / BEAT_BYTES;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      foreach (m_inflight[i]) m_inflight[i] = 1'b0;
      m_out = 0; m_code = 0; m_pulse = 0; m_stall = 0;
      m_left = 0; m_bsrc = 0; m_bop = 0; m_bsize = 0; m_bign = 1'b0;
    end else begin : step
      int nb, rsrc;
      bit af, df, retire;
      nb = 0; rsrc = 0; retire = 1'b0;
      af = a_valid && a_ready;
      df = d_valid && d_ready;
      if (m_out > 0 && !df) begin
        m_stall++;
        if (TIMEOUT_CYC != 0 && m_stall == TIMEOUT_CYC) nb |= 'h20;
      end else begin
        m_stall = 0;
      end
      if (df) begin
        if (m_left == 0) begin
          m_bsrc = int'(d_source); m_bop = int'(d_opcode); m_bsize = int'(d_size);
          m_bign = !m_inflight[d_source];
          if (m_bign) begin
            nb |= 'h02;
            m_left = num_beats(d_opcode == 3'd1, int'(d_size));
          end else begin
            if (m_get[d_source] != (d_opcode == 3'd1)) nb |= 'h04;
            if (m_size[d_source] != int'(d_size)) nb |= 'h08;
            m_left = num_beats(m_get[d_source], m_size[d_source]);
          end
        end else if (!m_bign && (int'(d_source) != m_bsrc || int'(d_opcode) != m_bop ||
                                 int'(d_size) != m_bsize)) begin
          nb |= 'h10;
        end
        m_left--;
        if (m_left == 0 && !m_bign) begin
          retire = 1'b1;
          rsrc = m_bsrc;
        end
      end
      if (retire) begin
        m_inflight[rsrc] = 1'b0;
        m_out--;
      end
      if (af) begin
        if (!(a_opcode inside {3'd0, 3'd1, 3'd4})) nb |= 'h40;
        else if (m_inflight[a_source]) nb |= 'h01;
        else begin
          m_inflight[a_source] = 1'b1;
          m_get[a_source]      = (a_opcode == 3'd4);
          m_size[a_source]     = int'(a_size);
          m_out++;
        end
      end
      m_pulse = (nb != 0) ? 1 : 0;
      m_code  = err_clear ? nb : (m_code | nb);
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clock) begin
    if (check_en) begin
      checkOutput("model_outstanding", int'(outstanding), m_out);
      checkOutput("model_err_pulse", int'(err_pulse), m_pulse);
      checkOutput("model_err_code", int'(err_code), m_code);
    end
  end

  task automatic applyStimulus(input bit av, input int aop, input int asz, input int asrc,
                               input bit dv, input int dop, input int dsz, input int dsrc,
                               input bit clr);
    a_valid = av; a_ready = 1'b1;
    a_opcode = 3'(aop); a_size = SIZE_W'(asz); a_source = SOURCE_W'(asrc);
    d_valid = dv; d_ready = 1'b1;
    d_opcode = 3'(dop); d_size = SIZE_W'(dsz); d_source = SOURCE_W'(dsrc);
    err_clear = clr;
    @(posedge clock); #1;
    a_valid = 1'b0; d_valid = 1'b0; err_clear = 1'b0;
  endtask

  task automatic sendA(input int op, input int sz, input int src);
    applyStimulus(1'b1, op, sz, src, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic sendD(input int op, input int sz, input int src);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, op, sz, src, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic randomPhase(input int cycles);
    int d_left, d_total, s;
    int d_src, d_op, d_sz;
    d_left = 0; d_total = 0; d_src = 0; d_op = 0; d_sz = 0;
    for (int c = 0; c < cycles; c++) begin
      a_valid  = ($urandom_range(0, 2) == 0);
      a_ready  = ($urandom_range(0, 3) != 0);
      a_source = SOURCE_W'($urandom_range(0, 15));
      a_size   = SIZE_W'($urandom_range(0, 4));
      case ($urandom_range(0, 9))
        0:       a_opcode = 3'd0;
        1:       a_opcode = 3'd1;
        9:       a_opcode = 3'($urandom_range(2, 3));
        default: a_opcode = 3'd4;
      endcase
      d_ready = ($urandom_range(0, 3) != 0);
      if (d_left == 0) begin
        d_valid = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          s = $urandom_range(0, 15);
          if (m_inflight[s]) begin
            d_src = s; d_sz = m_size[s]; d_op = m_get[s] ? 1 : 0;
            d_left = num_beats(m_get[s], m_size[s]);
            if ($urandom_range(0, 19) == 0) d_op = d_op ^ 1;
            if ($urandom_range(0, 19) == 0) d_sz = (d_sz + 1) % 16;
            d_total = d_left;
            d_valid = 1'b1;
          end else if ($urandom_range(0, 9) == 0) begin
            d_src = $urandom_range(100, 127); d_op = 0; d_sz = 0;
            d_left = 1; d_total = 1;
            d_valid = 1'b1;
          end
        end
      end else begin
        d_valid = 1'b1;
      end
      d_source = SOURCE_W'(d_src); d_opcode = 3'(d_op); d_size = SIZE_W'(d_sz);
      if (d_valid && d_left < d_total && $urandom_range(0, 14) == 0)
        d_source = SOURCE_W'(d_src ^ 1);
      err_clear = ($urandom_range(0, 39) == 0);
      @(posedge clock); #1;
      if (d_valid && d_ready) d_left--;
    end
    a_valid = 1'b0; d_valid = 1'b0; err_clear = 1'b0;
  endtask

  initial begin
    doReset();
    check_en = 1'b1;
    checkOutput("reset_outstanding", int'(outstanding), 0);
    checkOutput("reset_err_pulse", int'(err_pulse), 0);
    checkOutput("reset_err_code", int'(err_code), 0);

    randomPhase(3000);
    idle(20);

    // 1: four-beat Get completes cleanly
    doReset();
    sendA(4, 4, 5);
    checkOutput("t1_outstanding_1", int'(outstanding), 1);
    for (int i = 0; i < 4; i++) sendD(1, 4, 5);
    checkOutput("t1_outstanding_0", int'(outstanding), 0);
    checkOutput("t1_err_code", int'(err_code), 0);

    // 2: double PutFull on one ID
    doReset();
    sendA(0, 2, 3);
    sendA(0, 2, 3);
    checkOutput("t2_err_pulse", int'(err_pulse), 1);
    checkOutput("t2_err_code", int'(err_code), 'h01);
    checkOutput("t2_outstanding", int'(outstanding), 1);
    idle(1);
    checkOutput("t2_pulse_drop", int'(err_pulse), 0);

    // 3: idle-source response, opcode mismatch, clear with a new error
    doReset();
    sendD(0, 0, 9);
    checkOutput("t3_src_idle", int'(err_code), 'h02);
    sendA(4, 2, 2);
    sendD(0, 2, 2);
    checkOutput("t3_opcode", int'(err_code), 'h06);
    checkOutput("t3_outstanding", int'(outstanding), 0);
    applyStimulus(1'b0, 0, 0, 0, 1'b1, 0, 0, 9, 1'b1);
    checkOutput("t3_clear_new", int'(err_code), 'h02);

    // 4: watchdog fires exactly once at the limit
    doReset();
    sendA(4, 2, 7);
    idle(TIMEOUT_CYC - 1);
    checkOutput("t4_before_limit", int'(err_code), 0);
    idle(1);
    checkOutput("t4_timeout_code", int'(err_code), 'h20);
    checkOutput("t4_timeout_pulse", int'(err_pulse), 1);
    idle(1);
    checkOutput("t4_single_pulse", int'(err_pulse), 0);
    sendD(1, 2, 7);
    checkOutput("t4_outstanding", int'(outstanding), 0);
    checkOutput("t4_clean_pulse", int'(err_pulse), 0);

    // 5: same-cycle retire and reallocate of ID 4
    doReset();
    sendA(4, 2, 4);
    applyStimulus(1'b1, 4, 3, 4, 1'b1, 1, 2, 4, 1'b0);
    checkOutput("t5_outstanding", int'(outstanding), 1);
    checkOutput("t5_err_code", int'(err_code), 0);
    sendD(1, 3, 4);
    sendD(1, 3, 4);
    checkOutput("t5_done", int'(outstanding), 0);
    checkOutput("t5_no_err", int'(err_code), 0);

    // 6: source change mid-burst, clear, then reset mid-burst
    doReset();
    sendA(4, 3, 1);
    sendD(1, 3, 1);
    sendD(1, 3, 6);
    checkOutput("t6_burst", int'(err_code), 'h10);
    checkOutput("t6_retired", int'(outstanding), 0);
    applyStimulus(1'b0, 0, 0, 0, 1'b0, 0, 0, 0, 1'b1);
    checkOutput("t6_cleared", int'(err_code), 0);
    sendA(4, 4, 1);
    sendA(0, 0, 1);
    sendD(1, 4, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6_rst_outstanding", int'(outstanding), 0);
    checkOutput("t6_rst_pulse", int'(err_pulse), 0);
    checkOutput("t6_rst_code", int'(err_code), 0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    idle(3);
    checkOutput("t6_after_reset", int'(err_code), 0);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
